// File: rtl/step_sched.sv
// step_sched: consumer and sequencer for the 64-bit move queue.
//
// Pulls one queued move at a time and generates its step events. The
// interval between steps starts at the move's interval and changes linearly
// by the signed `add` after every step. Drives the stepper step/dir pins.
//
// Move entry layout (mq_data):
//   [63:32] interval, [31] dir, [30:16] count, [15:0] add (signed)
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   mq_data       head entry of the move queue
//   mq_avail      queue holds a valid move
//   mq_pull       combinational pop strobe for the head entry
//   step_o        step pin, held high PULSE_TICKS cycles per step
//   dir_o         direction pin, updated on each move-load edge
//   busy_o        a move is executing
//   underrun_o    sticky: a move with add != 0 ended with nothing queued
//   position_o    signed step position (only with STEP_SCHED_POSITION_EN)
//
// Optional feature: define STEP_SCHED_POSITION_EN to add the position_o
// output and its step counter.

module step_sched #(
  parameter int PULSE_TICKS = 4,
  parameter int TIMER_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mq_data,
  input  logic        mq_avail,
  output logic        mq_pull,
  output logic        step_o,
  output logic        dir_o,
  output logic        busy_o,
  output logic        underrun_o
`ifdef STEP_SCHED_POSITION_EN
  ,
  output logic [31:0] position_o
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] cur_q, cur_d;
  logic [14:0]        count_q, count_d;
  logic [15:0]        add_q, add_d;
  logic               dir_q, dir_d;
  logic [7:0]         pulse_q, pulse_d;
  logic               underrun_q, underrun_d;
`ifdef STEP_SCHED_POSITION_EN
  logic [31:0]        position_q, position_d;
`endif

  logic               step_evt;
  logic               last_step;
  logic [TIMER_W-1:0] new_interval;
  logic [TIMER_W-1:0] next_cur;
  logic [TIMER_W-1:0] add_ext;
  logic [14:0]        new_count;

  assign new_interval = TIMER_W'(mq_data[63:32]);
  assign new_count    = mq_data[30:16];
  assign add_ext      = TIMER_W'($signed(add_q));

  always_comb begin
    // A step fires on the cycle the timer reaches 1, so an interval of N
    // places the step N cycles after the load edge; 0 is clamped to 1.
    step_evt  = (state_q == RUN) && (timer_q == TIMER_W'(1));
    last_step = step_evt && (count_q == 15'd1);
    // Reset suppresses the pop so no entry is lost during reset.
    mq_pull   = !rst && mq_avail && ((state_q == IDLE) || last_step);
    next_cur  = cur_q + add_ext;

    state_d    = state_q;
    timer_d    = timer_q;
    cur_d      = cur_q;
    count_d    = count_q;
    add_d      = add_q;
    dir_d      = dir_q;
    pulse_d    = pulse_q;
    underrun_d = underrun_q;
`ifdef STEP_SCHED_POSITION_EN
    position_d = position_q;
`endif

    if (state_q == RUN) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    // A step reloads the pulse counter, so overlapping pulses merge.
    if (step_evt) begin
      count_d = count_q - 15'd1;
      cur_d   = next_cur;
      timer_d = (next_cur == '0) ? TIMER_W'(1) : next_cur;
      pulse_d = 8'(PULSE_TICKS);
`ifdef STEP_SCHED_POSITION_EN
      position_d = dir_q ? (position_q - 32'd1) : (position_q + 32'd1);
`endif
    end else if (pulse_q != 8'd0) begin
      pulse_d = pulse_q - 8'd1;
    end

    if (last_step) begin
      state_d = IDLE;
      if (!mq_avail && (add_q != 16'd0)) begin
        underrun_d = 1'b1;
      end
    end

    // A pull on the last-step cycle loads the next move on the same edge,
    // so back-to-back moves run with no gap cycle.
    if (mq_pull) begin
      cur_d   = new_interval;
      count_d = new_count;
      add_d   = mq_data[15:0];
      dir_d   = mq_data[31];
      if (new_count != 15'd0) begin
        state_d = RUN;
        timer_d = (new_interval == '0) ? TIMER_W'(1) : new_interval;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      cur_q      <= '0;
      count_q    <= '0;
      add_q      <= '0;
      dir_q      <= 1'b0;
      pulse_q    <= '0;
      underrun_q <= 1'b0;
`ifdef STEP_SCHED_POSITION_EN
      position_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_q      <= cur_d;
      count_q    <= count_d;
      add_q      <= add_d;
      dir_q      <= dir_d;
      pulse_q    <= pulse_d;
      underrun_q <= underrun_d;
`ifdef STEP_SCHED_POSITION_EN
      position_q <= position_d;
`endif
    end
  end

  assign step_o     = (pulse_q != 8'd0);
  assign dir_o      = dir_q;
  assign busy_o     = (state_q == RUN);
  assign underrun_o = underrun_q;
`ifdef STEP_SCHED_POSITION_EN
  assign position_o = position_q;
`endif

endmodule

// File: tb/tb_step_sched.sv
// tb_step_sched: self-checking bench for step_sched.
//
// Expected waveforms come from an event-time model: each move's step
// times are derived arithmetically from its interval/add, handovers are
// placed at the last step, and the per-cycle step/dir/busy/pull/underrun
// traces are painted from those event times. Position is checked when
// STEP_SCHED_POSITION_EN is defined.

module tb_step_sched;

  localparam int PT   = 4;
  localparam int MAXC = 4096;

  typedef struct {
    logic [31:0] interval;
    logic        dir;
    int          count;
    int          add;
  } move_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] mq_data = '0;
  logic        mq_avail = 1'b0;
  logic        mq_pull, step_o, dir_o, busy_o, underrun_o;
`ifdef STEP_SCHED_POSITION_EN
  logic [31:0] position_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  move_t       mq[$];
  bit          exp_step[MAXC];
  bit          exp_dir[MAXC];
  bit          exp_busy[MAXC];
  bit          exp_pull[MAXC];
  bit          exp_und[MAXC];
  logic [31:0] exp_pos[MAXC];
  logic [31:0] obs_pos[MAXC];
  logic [4:0]  obs_v[MAXC];
  int          exp_len;

  step_sched #(.PULSE_TICKS(PT), .TIMER_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .mq_data    (mq_data),
    .mq_avail   (mq_avail),
    .mq_pull    (mq_pull),
    .step_o     (step_o),
    .dir_o      (dir_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o)
`ifdef STEP_SCHED_POSITION_EN
    ,
    .position_o (position_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input move_t m);
    return {m.interval, m.dir, 15'(m.count), 16'(m.add)};
  endfunction

  function automatic logic [4:0] exp_vec(input int c);
    return {exp_step[c], exp_dir[c], exp_busy[c], exp_pull[c], exp_und[c]};
  endfunction

  // Cycle 0 is the first cycle after reset release with the queue presented.
  // A move loaded at the end of cycle L with effective interval T steps in
  // cycle L+T; step_o is high in the PT cycles after each step cycle.
  task automatic build_expected();
    int          c, idx, l, e, t, n, pos;
    logic [31:0] cur;
    move_t       mv;
    bit          chain;
    for (int i = 0; i < MAXC; i++) begin
      exp_step[i] = 0; exp_dir[i] = 0; exp_busy[i] = 0;
      exp_pull[i] = 0; exp_und[i] = 0; exp_pos[i] = '0;
    end
    n = mq.size(); c = 0; idx = 0; pos = 0;
    while (idx < n) begin
      exp_pull[c] = 1; l = c; chain = 1;
      while (chain) begin
        chain = 0; mv = mq[idx]; idx++;
        for (int i = l + 1; i < MAXC; i++) exp_dir[i] = mv.dir;
        if (mv.count == 0) begin
          c = l + 1;
        end else begin
          cur = mv.interval;
          t = l + ((cur == 0) ? 1 : int'(cur));
          e = t;
          for (int k = 0; k < mv.count; k++) begin
            e = t;
            for (int p = 1; p <= PT; p++) if (e + p < MAXC) exp_step[e + p] = 1;
            pos = mv.dir ? pos - 1 : pos + 1;
            for (int i = e + 1; i < MAXC; i++) exp_pos[i] = 32'(pos);
            cur = cur + 32'(mv.add);
            t = e + ((cur == 0) ? 1 : int'(cur));
          end
          for (int i = l + 1; i <= e && i < MAXC; i++) exp_busy[i] = 1;
          if (idx < n) begin
            exp_pull[e] = 1; l = e; chain = 1;
          end else begin
            if (mv.add != 0) for (int i = e + 1; i < MAXC; i++) exp_und[i] = 1;
            c = e + 1;
          end
        end
      end
    end
    exp_len = c + PT + 4;
  endtask

  // Resets the DUT, then serves the queue (popping on mq_pull) for ncyc
  // cycles, recording outputs mid-cycle.
  task automatic play(input int ncyc);
    int qi;
    bit pop;
    qi = 0; rst = 1'b1; mq_avail = 1'b0; mq_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      mq_avail = (qi < mq.size());
      mq_data  = mq_avail ? pack(mq[qi]) : '0;
      @(negedge clk);
      obs_v[c] = {step_o, dir_o, busy_o, mq_pull, underrun_o};
`ifdef STEP_SCHED_POSITION_EN
      obs_pos[c] = position_o;
`else
      obs_pos[c] = '0;
`endif
      pop = mq_pull;
      @(posedge clk);
      #1;
      if (pop && qi < mq.size()) qi++;
    end
    mq_avail = 1'b0;
    mq_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mq_avail = 1'b1;
    mq_data = pack('{32'd10, 1'b1, 3, 7});
    @(negedge clk);
    n_cmp++;
    if (mq_pull !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_pull: got %b, expected 0", mq_pull);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({step_o, dir_o, busy_o, underrun_o, mq_pull} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got step/dir/busy/und/pull=%b, expected 00000",
               {step_o, dir_o, busy_o, underrun_o, mq_pull});
    end
`ifdef STEP_SCHED_POSITION_EN
    n_cmp++;
    if (position_o !== 32'd0) begin
      n_fail++; $display("[TB] FAIL reset_position: got %0d, expected 0", position_o);
    end
`endif
    mq_avail = 1'b0;
  endtask

  task automatic test_basic();
    int rises;
    mq.delete();
    mq.push_back('{32'd10, 1'b0, 3, 0});
    build_expected();
    play(exp_len);
    for (int c = 0; c < exp_len; c++) begin
      n_cmp++;
      if (obs_v[c] !== exp_vec(c)) begin
        n_fail++;
        $display("[TB] FAIL basic_trace cycle %0d: got step/dir/busy/pull/und=%b, expected %b",
                 c, obs_v[c], exp_vec(c));
        break;
      end
    end
    rises = 0;
    for (int c = 1; c < exp_len; c++) if (obs_v[c][4] && !obs_v[c-1][4]) rises++;
    n_cmp++;
    if (rises !== 3) begin
      n_fail++; $display("[TB] FAIL basic_rise_count: got %0d, expected 3", rises);
    end
    n_cmp++;
    if ({obs_v[10][4], obs_v[11][4], obs_v[14][4], obs_v[15][4], obs_v[21][4], obs_v[31][4]} !== 6'b011011) begin
      n_fail++;
      $display("[TB] FAIL basic_step_times: got step@10,11,14,15,21,31=%b, expected 011011",
               {obs_v[10][4], obs_v[11][4], obs_v[14][4], obs_v[15][4], obs_v[21][4], obs_v[31][4]});
    end
    n_cmp++;
    if ({obs_v[30][2], obs_v[31][2]} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL basic_busy_end: got busy@30,31=%b, expected 10", {obs_v[30][2], obs_v[31][2]});
    end
  endtask

  task automatic test_decel();
    mq.delete();
    mq.push_back('{32'd100, 1'b0, 3, -10});
    build_expected();
    play(exp_len);
    for (int c = 0; c < exp_len; c++) begin
      n_cmp++;
      if (obs_v[c] !== exp_vec(c)) begin
        n_fail++;
        $display("[TB] FAIL decel_trace cycle %0d: got step/dir/busy/pull/und=%b, expected %b",
                 c, obs_v[c], exp_vec(c));
        break;
      end
    end
    n_cmp++;
    if ({obs_v[100][4], obs_v[101][4], obs_v[190][4], obs_v[191][4], obs_v[270][4], obs_v[271][4]} !== 6'b010101) begin
      n_fail++;
      $display("[TB] FAIL decel_spacing: got step@100,101,190,191,270,271=%b, expected 010101",
               {obs_v[100][4], obs_v[101][4], obs_v[190][4], obs_v[191][4], obs_v[270][4], obs_v[271][4]});
    end
    n_cmp++;
    if ({obs_v[270][0], obs_v[271][0]} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL decel_underrun: got und@270,271=%b, expected 01", {obs_v[270][0], obs_v[271][0]});
    end
  endtask

  task automatic test_back_to_back();
    mq.delete();
    mq.push_back('{32'd20, 1'b0, 2, 0});
    mq.push_back('{32'd30, 1'b1, 1, 0});
    build_expected();
    play(exp_len);
    for (int c = 0; c < exp_len; c++) begin
      n_cmp++;
      if (obs_v[c] !== exp_vec(c)) begin
        n_fail++;
        $display("[TB] FAIL b2b_trace cycle %0d: got step/dir/busy/pull/und=%b, expected %b",
                 c, obs_v[c], exp_vec(c));
        break;
      end
    end
    n_cmp++;
    if ({obs_v[40][1], obs_v[40][3], obs_v[41][3], obs_v[40][2], obs_v[41][2]} !== 5'b10111) begin
      n_fail++;
      $display("[TB] FAIL b2b_handover: got pull@40,dir@40,41,busy@40,41=%b, expected 10111",
               {obs_v[40][1], obs_v[40][3], obs_v[41][3], obs_v[40][2], obs_v[41][2]});
    end
    n_cmp++;
    if ({obs_v[70][4], obs_v[71][4]} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_step: got step@70,71=%b, expected 01", {obs_v[70][4], obs_v[71][4]});
    end
  endtask

  task automatic test_merge_and_zero();
    int high;
    mq.delete();
    mq.push_back('{32'd0, 1'b0, 2, 0});
    build_expected();
    play(exp_len);
    for (int c = 0; c < exp_len; c++) begin
      n_cmp++;
      if (obs_v[c] !== exp_vec(c)) begin
        n_fail++;
        $display("[TB] FAIL merge_trace cycle %0d: got step/dir/busy/pull/und=%b, expected %b",
                 c, obs_v[c], exp_vec(c));
        break;
      end
    end
    high = 0;
    for (int c = 0; c < exp_len; c++) if (obs_v[c][4]) high++;
    n_cmp++;
    if (high !== 5 || obs_v[2][4] !== 1'b1 || obs_v[6][4] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL merge_width: got %0d high cycles (step@2=%b,@6=%b), expected 5 (1,1)",
               high, obs_v[2][4], obs_v[6][4]);
    end

    mq.delete();
    mq.push_back('{32'd15, 1'b1, 0, 5});
    build_expected();
    play(exp_len + 8);
    for (int c = 0; c < exp_len + 8; c++) begin
      n_cmp++;
      if (obs_v[c] !== exp_vec(c)) begin
        n_fail++;
        $display("[TB] FAIL zero_count_trace cycle %0d: got step/dir/busy/pull/und=%b, expected %b",
                 c, obs_v[c], exp_vec(c));
        break;
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      mq.delete();
      n = $urandom_range(3, 5);
      for (int i = 0; i < n; i++) begin
        mq.push_back('{32'($urandom_range(16, 48)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 4)) - 2});
      end
      build_expected();
      play(exp_len);
      for (int c = 0; c < exp_len; c++) begin
        n_cmp++;
        if (obs_v[c] !== exp_vec(c)) begin
          n_fail++;
          $display("[TB] FAIL random%0d_trace cycle %0d: got step/dir/busy/pull/und=%b, expected %b",
                   r, c, obs_v[c], exp_vec(c));
          break;
        end
`ifdef STEP_SCHED_POSITION_EN
        n_cmp++;
        if (obs_pos[c] !== exp_pos[c]) begin
          n_fail++;
          $display("[TB] FAIL random%0d_position cycle %0d: got %0d, expected %0d",
                   r, c, $signed(obs_pos[c]), $signed(exp_pos[c]));
          break;
        end
`endif
      end
    end
  endtask

`ifdef STEP_SCHED_POSITION_EN
  task automatic test_position();
    mq.delete();
    mq.push_back('{32'd5, 1'b1, 4, 0});
    mq.push_back('{32'd5, 1'b0, 1, 0});
    build_expected();
    play(exp_len);
    for (int c = 0; c < exp_len; c++) begin
      n_cmp++;
      if (obs_pos[c] !== exp_pos[c] || obs_v[c] !== exp_vec(c)) begin
        n_fail++;
        $display("[TB] FAIL position_trace cycle %0d: got pos=%0d vec=%b, expected pos=%0d vec=%b",
                 c, $signed(obs_pos[c]), obs_v[c], $signed(exp_pos[c]), exp_vec(c));
        break;
      end
    end
    n_cmp++;
    if (obs_pos[21] !== 32'hFFFF_FFFC || obs_pos[26] !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("[TB] FAIL position_values: got %0d then %0d, expected -4 then -3",
               $signed(obs_pos[21]), $signed(obs_pos[26]));
    end
  endtask
`endif

  task automatic test_reset_mid_move();
    int w;
    rst = 1'b1; mq_avail = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq_data = pack('{32'd12, 1'b0, 1, 5});
    mq_avail = 1'b1;
    @(posedge clk);
    #1 mq_avail = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (underrun_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midrst_underrun_set: got %b, expected 1", underrun_o);
    end
    mq_data = pack('{32'd10, 1'b1, 3, 0});
    mq_avail = 1'b1;
    @(posedge clk);
    #1 mq_avail = 1'b0;
    w = 0;
    while (step_o !== 1'b1 && w < 100) begin
      @(posedge clk);
      #1 w++;
    end
    n_cmp++;
    if (w >= 100) begin
      n_fail++; $display("[TB] FAIL midrst_wait_step: got no step in %0d cycles, expected step", w);
    end
    mq_avail = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mq_pull !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrst_pull: got %b, expected 0", mq_pull);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({step_o, busy_o, underrun_o, dir_o} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: got step/busy/und/dir=%b, expected 0000",
               {step_o, busy_o, underrun_o, dir_o});
    end
    rst = 1'b0;
    mq_avail = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decel();
    test_back_to_back();
    test_merge_and_zero();
    test_random();
`ifdef STEP_SCHED_POSITION_EN
    test_position();
`endif
    test_reset_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
